// File: rtl/ahblite_master_stage.sv
// Per-master AHB-Lite front end: decodes the address phase to a slave request,
// holds it until granted, and muxes the selected slave's data-phase response.
// Optional build macro AHBLITE_MS_REMAP_EN adds a REMAP input swapping regions 0/1.
//
// state | meaning
// IDLE  | no data phase outstanding; ready to sample a new address
// DATA  | data phase in progress on slave dsel
// HOLD  | address to slave hsel waiting for grant; master stalled
// ERR1  | default-slave ERROR, first cycle (HREADY low)
// ERR2  | default-slave ERROR, second cycle (HREADY high)
module ahblite_master_stage #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] SLAVE_EN   = 16'h000F
) (
  input  logic                       HCLK,
  input  logic                       HRESETN,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
`ifdef AHBLITE_MS_REMAP_EN
  input  logic                       REMAP,
`endif
  output logic [31:0]                HRDATA,
  output logic                       HREADY,
  output logic                       HRESP,
  output logic [NUM_SLAVES-1:0]      REQ,
  output logic [31:0]                ADDR_O,
  output logic [1:0]                 TRANS_O,
  output logic                       WRITE_O,
  output logic [2:0]                 SIZE_O,
  input  logic [NUM_SLAVES-1:0]      GNT,
  input  logic [NUM_SLAVES-1:0]      SREADY,
  input  logic [32*NUM_SLAVES-1:0]   HRDATA_S,
  input  logic [NUM_SLAVES-1:0]      HRESP_S
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_HOLD,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_dsel;
  logic [SW-1:0]   r_hsel;
  logic [SW-1:0]   w_dsel_nxt;
  logic [SW-1:0]   w_hsel_nxt;
  logic [31:0]     r_haddr;
  logic [1:0]      r_htrans;
  logic            r_hwrite;
  logic [2:0]      r_hsize;
  logic            w_hold_ld;

  logic [3:0]      w_region;
  logic [3:0]      w_target;
  logic            w_valid;
  logic [SW-1:0]   w_tidx;
  logic            w_dpr;
  logic            w_new;

  // Region decode; the remap swap is applied before the enable check so the
  // target slave's enable bit governs validity.
  always_comb begin
    w_region = HADDR[31:28];
    w_target = w_region;
`ifdef AHBLITE_MS_REMAP_EN
    if (REMAP && (w_region[3:1] == 3'b000))
      w_target = {w_region[3:1], ~w_region[0]};
`endif
    w_valid = ({1'b0, w_target} < 5'(NUM_SLAVES)) && SLAVE_EN[w_target];
    w_tidx  = w_target[SW-1:0];
  end

  always_comb begin
    w_dpr = 1'b1;
    unique case (r_state)
      S_IDLE:  w_dpr = 1'b1;
      S_DATA:  w_dpr = SREADY[r_dsel];
      S_HOLD:  w_dpr = 1'b0;
      S_ERR1:  w_dpr = 1'b0;
      S_ERR2:  w_dpr = 1'b1;
      default: w_dpr = 1'b1;
    endcase
  end

  // HOLD and ERR1 always have dpr low, so this only fires in IDLE/DATA/ERR2.
  assign w_new  = w_dpr & HTRANS[1];
  assign HREADY = w_dpr;

  always_comb begin
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    unique case (r_state)
      S_DATA: begin
        HRESP  = HRESP_S[r_dsel];
        HRDATA = HRDATA_S[{r_dsel, 5'b00000} +: 32];
      end
      S_ERR1, S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    REQ     = '0;
    ADDR_O  = 32'h0;
    TRANS_O = 2'b00;
    WRITE_O = 1'b0;
    SIZE_O  = 3'b000;
    if (r_state == S_HOLD) begin
      REQ[r_hsel] = 1'b1;
      ADDR_O      = r_haddr;
      TRANS_O     = r_htrans;
      WRITE_O     = r_hwrite;
      SIZE_O      = r_hsize;
    end else if (w_new && w_valid) begin
      REQ[w_tidx] = 1'b1;
      ADDR_O      = HADDR;
      TRANS_O     = HTRANS;
      WRITE_O     = HWRITE;
      SIZE_O      = HSIZE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dsel_nxt  = r_dsel;
    w_hsel_nxt  = r_hsel;
    w_hold_ld   = 1'b0;
    unique case (r_state)
      S_HOLD: begin
        if (GNT[r_hsel]) begin
          w_state_nxt = S_DATA;
          w_dsel_nxt  = r_hsel;
        end
      end
      S_ERR1: w_state_nxt = S_ERR2;
      default: begin
        if (w_dpr) begin
          if (!HTRANS[1]) begin
            w_state_nxt = S_IDLE;
          end else if (!w_valid) begin
            w_state_nxt = S_ERR1;
          end else if (GNT[w_tidx]) begin
            w_state_nxt = S_DATA;
            w_dsel_nxt  = w_tidx;
          end else begin
            w_state_nxt = S_HOLD;
            w_hsel_nxt  = w_tidx;
            w_hold_ld   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state  <= S_IDLE;
      r_dsel   <= '0;
      r_hsel   <= '0;
      r_haddr  <= 32'h0;
      r_htrans <= 2'b00;
      r_hwrite <= 1'b0;
      r_hsize  <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_dsel  <= w_dsel_nxt;
      r_hsel  <= w_hsel_nxt;
      if (w_hold_ld) begin
        r_haddr  <= HADDR;
        r_htrans <= HTRANS;
        r_hwrite <= HWRITE;
        r_hsize  <= HSIZE;
      end
    end
  end

endmodule

// File: tb/tb_ahblite_master_stage.sv
// Directed bench for ahblite_master_stage: drives at negedge, checks 1ns later.
module tb_ahblite_master_stage;

  localparam int NS = 4;

  logic           HCLK = 1'b0;
  logic           HRESETN;
  logic [31:0]    HADDR;
  logic [1:0]     HTRANS;
  logic           HWRITE;
  logic [2:0]     HSIZE;
  logic [31:0]    HRDATA;
  logic           HREADY;
  logic           HRESP;
  logic [NS-1:0]  REQ;
  logic [31:0]    ADDR_O;
  logic [1:0]     TRANS_O;
  logic           WRITE_O;
  logic [2:0]     SIZE_O;
  logic [NS-1:0]  GNT;
  logic [NS-1:0]  SREADY;
  logic [32*NS-1:0] HRDATA_S;
  logic [NS-1:0]  HRESP_S;
`ifdef AHBLITE_MS_REMAP_EN
  logic           REMAP = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 HCLK = ~HCLK;

  ahblite_master_stage #(.NUM_SLAVES(NS), .SLAVE_EN(16'h000F)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
`ifdef AHBLITE_MS_REMAP_EN
    .REMAP(REMAP),
`endif
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .REQ(REQ), .ADDR_O(ADDR_O), .TRANS_O(TRANS_O), .WRITE_O(WRITE_O), .SIZE_O(SIZE_O),
    .GNT(GNT), .SREADY(SREADY), .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Apply one cycle's inputs at the falling edge, then let them settle.
  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w,
                       input logic [NS-1:0] g, input logic [NS-1:0] s,
                       input logic [NS-1:0] e);
    @(negedge HCLK);
    HADDR  = a;
    HTRANS = t;
    HWRITE = w;
    HSIZE  = 3'd2;
    GNT    = g;
    SREADY = s;
    HRESP_S = e;
    #1;
  endtask

  initial begin
    HRESETN = 1'b0;
    HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
    GNT = '0; SREADY = '0; HRESP_S = '0;
    HRDATA_S = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    #2;
    chk("rst_hready", HREADY, 1);
    chk("rst_hresp",  HRESP, 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_req",    REQ, 0);
    chk("rst_addr_o", ADDR_O, 0);
    chk("rst_trans_o", TRANS_O, 0);
    @(negedge HCLK);
    HRESETN = 1'b1;

    // Write to slave 1, granted immediately, zero wait
    drive(32'h1000_0000, 2'b10, 1'b1, 4'b0010, 4'b0000, 4'b0000);
    chk("wr_req",     REQ, 4'b0010);
    chk("wr_addr_o",  ADDR_O, 32'h1000_0000);
    chk("wr_write_o", WRITE_O, 1);
    chk("wr_trans_o", TRANS_O, 2'b10);
    chk("wr_size_o",  SIZE_O, 3'd2);
    chk("wr_hready0", HREADY, 1);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    chk("wr_req_off", REQ, 0);
    chk("wr_hready1", HREADY, 1);
    chk("wr_dsel1",   HRDATA, 32'hA000_0001);

    // Read slave 2, grant delayed, one wait state
    HRDATA_S[95:64] = 32'hDEAD_BEEF;
    drive(32'h2000_0004, 2'b10, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk("rd_req_a",    REQ, 4'b0100);
    chk("rd_hready_a", HREADY, 1);
    drive(32'h3000_0008, 2'b10, 1'b1, 4'b1000, 4'b1111, 4'b0000);
    chk("rd_req_h1",    REQ, 4'b0100);
    chk("rd_addr_h1",   ADDR_O, 32'h2000_0004);
    chk("rd_write_h1",  WRITE_O, 0);
    chk("rd_hready_h1", HREADY, 0);
    drive(32'h3000_0008, 2'b10, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    chk("rd_req_h2",    REQ, 4'b0100);
    chk("rd_hready_h2", HREADY, 0);
    drive(32'h3000_0008, 2'b10, 1'b1, 4'b0100, 4'b0000, 4'b0000);
    chk("rd_req_h3",    REQ, 4'b0100);
    chk("rd_addr_h3",   ADDR_O, 32'h2000_0004);
    chk("rd_hready_h3", HREADY, 0);
    drive(32'h3000_0008, 2'b10, 1'b1, 4'b1000, 4'b0000, 4'b0000);
    chk("rd_req_wait",  REQ, 0);
    chk("rd_hready_w",  HREADY, 0);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    chk("rd_hready_r",  HREADY, 1);
    chk("rd_hrdata",    HRDATA, 32'hDEAD_BEEF);
    chk("rd_hresp",     HRESP, 0);

    // Unmapped region 7, then region 4 (just beyond NUM_SLAVES) from ERR2
    drive(32'h7000_0000, 2'b10, 1'b0, 4'b1111, 4'b0000, 4'b0000);
    chk("err_req",     REQ, 0);
    chk("err_hready0", HREADY, 1);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk("err1_hready", HREADY, 0);
    chk("err1_hresp",  HRESP, 1);
    chk("err1_hrdata", HRDATA, 0);
    drive(32'h4000_0000, 2'b10, 1'b0, 4'b1111, 4'b0000, 4'b0000);
    chk("err2_hready", HREADY, 1);
    chk("err2_hresp",  HRESP, 1);
    chk("err2_req",    REQ, 0);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk("r4_err1_hready", HREADY, 0);
    chk("r4_err1_hresp",  HRESP, 1);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk("r4_err2_hready", HREADY, 1);
    chk("r4_err2_hresp",  HRESP, 1);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk("err_okay_hresp",  HRESP, 0);
    chk("err_okay_hready", HREADY, 1);

    // Back-to-back slave 0 then slave 3
    drive(32'h0000_0010, 2'b10, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    chk("b2b_req0", REQ, 4'b0001);
    drive(32'h3000_0020, 2'b10, 1'b0, 4'b1000, 4'b0001, 4'b0000);
    chk("b2b_req3",    REQ, 4'b1000);
    chk("b2b_hready0", HREADY, 1);
    chk("b2b_hrdata0", HRDATA, 32'hA000_0000);
    chk("b2b_addr3",   ADDR_O, 32'h3000_0020);
    drive(32'h0000_0030, 2'b10, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    chk("b2b_stall_req",  REQ, 0);
    chk("b2b_stall_rdy",  HREADY, 0);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b1000, 4'b0000);
    chk("b2b_hrdata3", HRDATA, 32'hA000_0003);
    chk("b2b_hready3", HREADY, 1);

    // Slave 1 error response passes through
    drive(32'h1000_0040, 2'b10, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    chk("serr_req", REQ, 4'b0010);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0010);
    chk("serr_hready0", HREADY, 0);
    chk("serr_hresp0",  HRESP, 1);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b0010, 4'b0010);
    chk("serr_hready1", HREADY, 1);
    chk("serr_hresp1",  HRESP, 1);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk("serr_idle_hresp", HRESP, 0);

    // Reset asserted while holding
    drive(32'h2000_0000, 2'b10, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk("rh_req_a", REQ, 4'b0100);
    drive(32'h2000_0000, 2'b10, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk("rh_req_hold",    REQ, 4'b0100);
    chk("rh_hready_hold", HREADY, 0);
    @(negedge HCLK);
    HRESETN = 1'b0;
    HTRANS  = 2'b00;
    #1;
    chk("rh_req_rst",    REQ, 0);
    chk("rh_hready_rst", HREADY, 1);
    chk("rh_hresp_rst",  HRESP, 0);
    chk("rh_addr_rst",   ADDR_O, 0);
    @(negedge HCLK);
    HRESETN = 1'b1;
    drive(32'h3000_0000, 2'b10, 1'b1, 4'b1000, 4'b0000, 4'b0000);
    chk("rh_post_req",  REQ, 4'b1000);
    chk("rh_post_addr", ADDR_O, 32'h3000_0000);
    drive(32'h0, 2'b00, 1'b0, 4'b0000, 4'b1000, 4'b0000);
    chk("rh_post_hready", HREADY, 1);
    chk("rh_post_hrdata", HRDATA, 32'hA000_0003);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
